// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared states, press codes and display constants for lock_controller
// ST_SET exists only when LOCK_CODE_CHANGE_EN is defined.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_LOCKOUT = 3'd3
`ifdef LOCK_CODE_CHANGE_EN
        ,
        ST_SET     = 3'd4
`endif
    } lock_state_e;

    localparam logic [2:0] PRESS_SHORT = 3'b001;
    localparam logic [2:0] PRESS_LONG  = 3'b010;

    localparam logic [3:0] DISP_OPEN = 4'h0;
    localparam logic [3:0] DISP_LOCK = 4'hF;

    localparam int unsigned TIMER_W_MIN = 17;

    // Digit 0 lives in the top nibble, digit 3 in the bottom nibble.
    function automatic logic [15:0] set_digit(input logic [15:0] code,
                                              input logic [1:0]  idx,
                                              input logic [3:0]  val);
        logic [15:0] r;
        r = code;
        case (idx)
            2'd0:    r[15:12] = val;
            2'd1:    r[11:8]  = val;
            2'd2:    r[7:4]   = val;
            default: r[3:0]   = val;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - loadable down-counter that stops at zero
// Shared between the OPEN and LOCKOUT intervals.
module lock_timer #(
    parameter int unsigned W = 17
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/lock_controller.sv
// rtl/lock_controller.sv - 4-digit code entry, compare, unlock and lockout sequencing
// LOCK_CODE_CHANGE_EN adds the SET state for rewriting the stored code from OPEN.
module lock_controller
    import lock_pkg::*;
#(
    parameter logic [15:0] CODE           = 16'h1234,
    parameter int unsigned UNLOCK_CYCLES  = 50000,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] enc,
    input  logic [2:0] pb_press_type,
    output logic [3:0] display_value,
    output logic [1:0] display_select,
    output logic       unlocked,
    output logic       lockout,
    output logic       fail
);

    localparam int unsigned MAX_CYC = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TIMER_W = ($clog2(MAX_CYC) > TIMER_W_MIN) ? $clog2(MAX_CYC) : TIMER_W_MIN;
    localparam int unsigned FAIL_W  = $clog2(MAX_FAILS + 1);

    lock_state_e       state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [FAIL_W-1:0] fail_cnt_inc;
    logic [15:0]       digits_q, digits_d;
    logic [15:0]       digits_new;
    logic [15:0]       stored_code;

    logic [3:0]        display_value_q, display_value_d;
    logic [1:0]        display_select_q, display_select_d;
    logic              unlocked_q, unlocked_d;
    logic              lockout_q, lockout_d;
    logic              fail_q, fail_d;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_load_val;
    logic               tmr_en;
    logic               tmr_zero;

    logic press_short;
    logic press_long;

    assign press_short  = (pb_press_type == PRESS_SHORT);
    assign press_long   = (pb_press_type == PRESS_LONG);
    assign digits_new   = set_digit(digits_q, idx_q, enc);
    assign fail_cnt_inc = fail_cnt_q + FAIL_W'(1);

`ifdef LOCK_CODE_CHANGE_EN
    logic [15:0] code_q, code_d;
    assign stored_code = code_q;
`else
    assign stored_code = CODE;
`endif

    lock_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rstn       (rstn),
        .load       (tmr_load),
        .load_value (tmr_load_val),
        .en         (tmr_en),
        .zero       (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        fail_cnt_d   = fail_cnt_q;
        digits_d     = digits_q;
`ifdef LOCK_CODE_CHANGE_EN
        code_d       = code_q;
`endif
        fail_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;

        case (state_q)
            ST_ENTRY: begin
                if (press_short) begin
                    digits_d = digits_new;
                    if (idx_q == 2'd3) begin
                        state_d = ST_CHECK;
                        idx_d   = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else if (press_long) begin
                    digits_d = '0;
                    idx_d    = 2'd0;
                end
            end

            ST_CHECK: begin
                digits_d = '0;
                if (digits_q == stored_code) begin
                    state_d      = ST_OPEN;
                    fail_cnt_d   = '0;
                    tmr_load     = 1'b1;
                    tmr_load_val = TIMER_W'(UNLOCK_CYCLES - 1);
                end else begin
                    fail_d = 1'b1;
                    if (fail_cnt_inc == FAIL_W'(MAX_FAILS)) begin
                        state_d      = ST_LOCKOUT;
                        fail_cnt_d   = '0;
                        tmr_load     = 1'b1;
                        tmr_load_val = TIMER_W'(LOCKOUT_CYCLES - 1);
                    end else begin
                        state_d    = ST_ENTRY;
                        fail_cnt_d = fail_cnt_inc;
                    end
                end
            end

            ST_OPEN: begin
                tmr_en = 1'b1;
                if (press_short) begin
                    state_d = ST_ENTRY;
`ifdef LOCK_CODE_CHANGE_EN
                end else if (press_long) begin
                    state_d  = ST_SET;
                    idx_d    = 2'd0;
                    digits_d = '0;
`endif
                end else if (tmr_zero) begin
                    state_d = ST_ENTRY;
                end
            end

            ST_LOCKOUT: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    state_d = ST_ENTRY;
                end
            end

`ifdef LOCK_CODE_CHANGE_EN
            // Timer stays frozen here; an abort restarts the full open window.
            ST_SET: begin
                if (press_short) begin
                    if (idx_q == 2'd3) begin
                        code_d   = digits_new;
                        digits_d = '0;
                        idx_d    = 2'd0;
                        state_d  = ST_ENTRY;
                    end else begin
                        digits_d = digits_new;
                        idx_d    = idx_q + 2'd1;
                    end
                end else if (press_long) begin
                    state_d      = ST_OPEN;
                    digits_d     = '0;
                    idx_d        = 2'd0;
                    tmr_load     = 1'b1;
                    tmr_load_val = TIMER_W'(UNLOCK_CYCLES - 1);
                end
            end
`endif

            default: begin
                state_d = ST_ENTRY;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        unlocked_d = (state_d == ST_OPEN);
`ifdef LOCK_CODE_CHANGE_EN
        if (state_d == ST_SET) begin
            unlocked_d = 1'b1;
        end
`endif
        lockout_d = (state_d == ST_LOCKOUT);

        case (state_d)
            ST_OPEN: begin
                display_value_d  = DISP_OPEN;
                display_select_d = 2'd0;
            end
            ST_LOCKOUT: begin
                display_value_d  = DISP_LOCK;
                display_select_d = 2'd0;
            end
            default: begin
                display_value_d  = enc;
                display_select_d = idx_d;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= ST_ENTRY;
            idx_q            <= 2'd0;
            fail_cnt_q       <= '0;
            digits_q         <= '0;
            display_value_q  <= 4'h0;
            display_select_q <= 2'd0;
            unlocked_q       <= 1'b0;
            lockout_q        <= 1'b0;
            fail_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            fail_cnt_q       <= fail_cnt_d;
            digits_q         <= digits_d;
            display_value_q  <= display_value_d;
            display_select_q <= display_select_d;
            unlocked_q       <= unlocked_d;
            lockout_q        <= lockout_d;
            fail_q           <= fail_d;
        end
    end

`ifdef LOCK_CODE_CHANGE_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            code_q <= CODE;
        end else begin
            code_q <= code_d;
        end
    end
`endif

    assign display_value  = display_value_q;
    assign display_select = display_select_q;
    assign unlocked       = unlocked_q;
    assign lockout        = lockout_q;
    assign fail           = fail_q;

endmodule

// File: tb/tb_lock_controller.sv
// tb/tb_lock_controller.sv - self-checking bench for lock_controller with shortened timers
// Exercises the code-change path when LOCK_CODE_CHANGE_EN is defined.
module tb_lock_controller;

    localparam int UNL = 20;
    localparam int LCK = 30;
    localparam int MF  = 3;
    localparam logic [15:0] FACTORY = 16'h1234;
    localparam logic [2:0]  P_SHORT = 3'b001;
    localparam logic [2:0]  P_LONG  = 3'b010;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] enc = 4'h0;
    logic [2:0] pb_press_type = 3'b000;
    logic [3:0] display_value;
    logic [1:0] display_select;
    logic       unlocked;
    logic       lockout;
    logic       fail;

    always #5 clk = ~clk;

    lock_controller #(
        .CODE           (FACTORY),
        .UNLOCK_CYCLES  (UNL),
        .MAX_FAILS      (MF),
        .LOCKOUT_CYCLES (LCK)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .enc            (enc),
        .pb_press_type  (pb_press_type),
        .display_value  (display_value),
        .display_select (display_select),
        .unlocked       (unlocked),
        .lockout        (lockout),
        .fail           (fail)
    );

    typedef struct packed {
        logic unl;
        logic lck;
        logic fl;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_code = FACTORY;
    int          model_fails = 0;

    task automatic press(input logic [2:0] t, input logic [3:0] v);
        @(negedge clk);
        enc = v;
        pb_press_type = t;
        @(negedge clk);
        pb_press_type = 3'b000;
    endtask

    task automatic press_digits(input logic [15:0] c);
        for (int i = 0; i < 4; i++) begin
            press(P_SHORT, c[15-4*i -: 4]);
        end
    endtask

    task automatic push_expected(input logic [15:0] c);
        exp_t e;
        if (c == model_code) begin
            e = '{unl: 1'b1, lck: 1'b0, fl: 1'b0};
            model_fails = 0;
        end else begin
            model_fails++;
            if (model_fails == MF) begin
                e = '{unl: 1'b0, lck: 1'b1, fl: 1'b1};
                model_fails = 0;
            end else begin
                e = '{unl: 1'b0, lck: 1'b0, fl: 1'b1};
            end
        end
        sb.push_back(e);
    endtask

    task automatic enter_code(input logic [15:0] c);
        press_digits(c);
        push_expected(c);
    endtask

    // Called one edge after the final press: nothing visible yet, then the verdict.
    task automatic check_outcome(input string name);
        exp_t e;
        checks++;
        if (unlocked !== 1'b0 || fail !== 1'b0) begin
            errors++;
            $display("FAIL %s_early got unl=%b fail=%b required 0 0", name, unlocked, fail);
        end
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard_empty got 0 entries required 1", name);
        end else begin
            e = sb.pop_front();
            if ({unlocked, lockout, fail} !== e) begin
                errors++;
                $display("FAIL %s_outcome got unl/lck/fail=%b required %b", name, {unlocked, lockout, fail}, e);
            end
        end
    endtask

    task automatic check_open_length(input string name);
        int cnt;
        cnt = 1;
        while (unlocked === 1'b1 && cnt <= UNL + 5) begin
            @(negedge clk);
            if (unlocked === 1'b1) cnt++;
        end
        checks++;
        if (cnt != UNL) begin
            errors++;
            $display("FAIL %s_open_cycles got %0d required %0d", name, cnt, UNL);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({display_value, display_select, unlocked, lockout, fail} !== 9'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0", {display_value, display_select, unlocked, lockout, fail});
        end
        rstn = 1'b1;
    endtask

    task automatic test_correct_code();
        enter_code(16'h1234);
        check_outcome("correct");
        checks++;
        if (display_value !== 4'h0 || display_select !== 2'd0) begin
            errors++;
            $display("FAIL open_display got %h/%0d required 0/0", display_value, display_select);
        end
        check_open_length("correct");
    endtask

    task automatic test_wrong_code();
        enter_code(16'h1235);
        check_outcome("wrong");
        @(negedge clk);
        checks++;
        if (fail !== 1'b0) begin
            errors++;
            $display("FAIL fail_pulse_width got %b required 0", fail);
        end
        enc = 4'h7;
        @(negedge clk);
        checks++;
        if (display_value !== 4'h7 || display_select !== 2'd0) begin
            errors++;
            $display("FAIL entry_display got %h/%0d required 7/0", display_value, display_select);
        end
    endtask

    task automatic test_lockout();
        int cnt;
        logic disp_bad;
        enter_code(16'h4321);
        check_outcome("wrong2");
        enter_code(16'h0000);
        check_outcome("wrong3");
        cnt = 1;
        disp_bad = 1'b0;
        while (lockout === 1'b1 && cnt <= LCK + 5) begin
            enc = 4'h1;
            pb_press_type = (cnt % 4 == 1) ? P_SHORT : ((cnt % 4 == 3) ? P_LONG : 3'b000);
            @(negedge clk);
            if (lockout === 1'b1) begin
                cnt++;
                if (display_value !== 4'hF) disp_bad = 1'b1;
            end
        end
        pb_press_type = 3'b000;
        checks++;
        if (cnt != LCK) begin
            errors++;
            $display("FAIL lockout_cycles got %0d required %0d", cnt, LCK);
        end
        checks++;
        if (disp_bad !== 1'b0) begin
            errors++;
            $display("FAIL lockout_display got non-F required F");
        end
        checks++;
        if (display_select !== 2'd0) begin
            errors++;
            $display("FAIL post_lockout_idx got %0d required 0", display_select);
        end
        enter_code(16'h1234);
        check_outcome("after_lockout");
        check_open_length("after_lockout");
    endtask

    task automatic test_long_press_clear();
        press(P_SHORT, 4'h1);
        press(P_SHORT, 4'h2);
        checks++;
        if (display_select !== 2'd2) begin
            errors++;
            $display("FAIL mid_entry_idx got %0d required 2", display_select);
        end
        press(P_LONG, 4'h0);
        checks++;
        if (display_select !== 2'd0) begin
            errors++;
            $display("FAIL long_clear_idx got %0d required 0", display_select);
        end
        enter_code(16'h1234);
        check_outcome("after_clear");
        check_open_length("after_clear");
    endtask

    task automatic test_relock();
        enter_code(16'h1234);
        check_outcome("relock_open");
        repeat (5) @(negedge clk);
        press(P_SHORT, 4'h0);
        checks++;
        if (unlocked !== 1'b0) begin
            errors++;
            $display("FAIL relock got unl=%b required 0", unlocked);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] c;
        c = 16'h4321;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            enc = c[15-4*i -: 4];
            pb_press_type = P_SHORT;
            @(negedge clk);
        end
        push_expected(c);
        // This press lands while in CHECK and must be dropped.
        enc = 4'h9;
        pb_press_type = P_SHORT;
        @(negedge clk);
        pb_press_type = 3'b000;
        begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL b2b_scoreboard_empty got 0 entries required 1");
            end else begin
                e = sb.pop_front();
                if ({unlocked, lockout, fail} !== e) begin
                    errors++;
                    $display("FAIL b2b_outcome got %b required %b", {unlocked, lockout, fail}, e);
                end
            end
        end
        press(P_SHORT, 4'h5);
        checks++;
        if (display_select !== 2'd1) begin
            errors++;
            $display("FAIL check_press_dropped got idx %0d required 1", display_select);
        end
        press(P_LONG, 4'h0);
    endtask

    task automatic test_reset_in_lockout();
        while (model_fails != MF - 1) begin
            enter_code(16'hAAAA);
            check_outcome("pre_lock");
        end
        enter_code(16'hBBBB);
        check_outcome("lock_for_reset");
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({display_value, display_select, unlocked, lockout, fail} !== 9'h0) begin
            errors++;
            $display("FAIL async_reset got %h required 0", {display_value, display_select, unlocked, lockout, fail});
        end
        model_fails = 0;
        model_code = FACTORY;
        @(negedge clk);
        rstn = 1'b1;
        enter_code(16'h5555);
        check_outcome("post_reset_wrong");
        enter_code(16'h1234);
        check_outcome("post_reset_open");
        check_open_length("post_reset");
    endtask

`ifdef LOCK_CODE_CHANGE_EN
    task automatic test_code_change();
        enter_code(16'h1234);
        check_outcome("cc_open");
        press(P_LONG, 4'h0);
        checks++;
        if (unlocked !== 1'b1) begin
            errors++;
            $display("FAIL set_unlocked got %b required 1", unlocked);
        end
        press_digits(16'h9876);
        checks++;
        if (unlocked !== 1'b0) begin
            errors++;
            $display("FAIL set_exit got unl=%b required 0", unlocked);
        end
        model_code = 16'h9876;
        enter_code(16'h1234);
        check_outcome("cc_old_fails");
        enter_code(16'h9876);
        check_outcome("cc_new_opens");
        check_open_length("cc_new");
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_correct_code();
        test_wrong_code();
        test_lockout();
        test_long_press_clear();
        test_relock();
        test_back_to_back();
        test_reset_in_lockout();
`ifdef LOCK_CODE_CHANGE_EN
        test_code_change();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_controller.md
# lock_controller

Sequencing controller between the rotary encoder front end and the seven-segment driver. Consumes the 4-bit encoder count and the push-button press-type pulses, and assembles a 4-digit entry code digit by digit. It compares the entry against a stored code and drives the unlock and lockout outputs. It also supplies the display value and digit select to the seven-segment driver. Runs in the 10 kHz clock domain.

## Interface
- CODE, 16'h1234: factory code, digit 0 in [15:12] through digit 3 in [3:0]
- UNLOCK_CYCLES, 50000: cycles `unlocked` stays high (5 s at 10 kHz)
- MAX_FAILS, 3: consecutive wrong entries that trigger lockout
- LOCKOUT_CYCLES, 100000: lockout duration in cycles (10 s)
- clk  in  1  10 kHz system clock
- rstn  in  1  asynchronous active-low reset
- enc  in  4  live encoder count
- pb_press_type  in  3  one-cycle press pulse: 3'b001 short, 3'b010 long; any other value is treated as no press
- display_value  out  4  nibble sent to the seven-segment driver
- display_select  out  2  digit position sent to the seven-segment driver
- unlocked  out  1  high while the lock is open
- lockout  out  1  high during the lockout period
- fail  out  1  one-cycle pulse on each wrong entry

## Operation
- States: ENTRY, CHECK, OPEN, LOCKOUT, plus SET when the macro is defined.
- Reset values:
  - state ENTRY, idx 0, fail_cnt 0, entry digits 0, stored code CODE.
  - All outputs 0.
- ENTRY:
  - display_value = enc and display_select = idx.
  - A short press latches enc into digit[idx] and increments idx.
  - On the 4th latch, go to CHECK with idx reset to 0.
  - A long press clears all digits, sets idx to 0 and stays in ENTRY.
- CHECK: one cycle; compare all 16 entry bits with the stored code.
  - Match: go to OPEN, clear fail_cnt, load the timer with UNLOCK_CYCLES-1.
  - Mismatch: pulse fail and increment fail_cnt. If the new fail_cnt equals MAX_FAILS, go to LOCKOUT, load the timer with LOCKOUT_CYCLES-1 and clear fail_cnt. Otherwise go to ENTRY.
  - The entry digits are cleared on exit from CHECK.
- OPEN: unlocked=1, display_value=4'h0, display_select=0.
  - Timer reaching 0 returns to ENTRY.
  - A short press relocks immediately, returning to ENTRY on the next cycle.
- LOCKOUT: lockout=1, display_value=4'hF. All presses are ignored. Timer reaching 0 returns to ENTRY.
- Width rules:
  - idx is 2 bits.
  - fail_cnt is wide enough to hold MAX_FAILS.
  - The timer is 17 bits minimum and saturates at 0.
  - The encoder value is taken as-is; it wraps 4'hF to 4'h0 upstream.

## Timing
- The press pulse is sampled on the cycle it is high. The state and idx update appear on the next edge.
- unlocked rises one cycle after CHECK, i.e. two edges after the 4th short press.
- unlocked is high for exactly UNLOCK_CYCLES cycles unless a short press relocks it. lockout is high for exactly LOCKOUT_CYCLES cycles.
- fail is high only in the cycle following CHECK.
- Presses arriving while in CHECK or LOCKOUT are dropped, not queued.
- display outputs are registered, with one cycle of latency from enc.
- rstn assertion at any point, including mid-entry, OPEN or LOCKOUT, returns immediately to the reset values. The stored code reverts to CODE.

## Configuration
- LOCK_CODE_CHANGE_EN defined:
  - A long press in OPEN enters SET. SET uses the same digit entry as ENTRY.
  - After the 4th short press, the new code is written to the stored code and the state returns to ENTRY with unlocked=0.
  - A long press in SET aborts back to OPEN and reloads the timer. The OPEN timer is frozen while in SET.
- LOCK_CODE_CHANGE_EN not defined: no SET state; long presses in OPEN are ignored; the stored code is constant CODE.

## Structure
- lock_pkg holds:
  - The state enum.
  - Press-type constants PRESS_SHORT=3'b001 and PRESS_LONG=3'b010.
  - Display constants DISP_OPEN=4'h0 and DISP_LOCK=4'hF.
- Sub-module lock_timer: a loadable 17-bit down-counter with load, load value and a zero flag, shared by OPEN and LOCKOUT.

## Test plan
- Correct code: enter 1,2,3,4 with short presses → unlocked=1 two edges after the last press, for 50000 cycles, then ENTRY.
- Wrong code 1,2,3,5 → one fail pulse, fail_cnt=1, still in ENTRY with unlocked=0.
- Three wrong entries → lockout=1 for 100000 cycles, display_value=4'hF, presses ignored; a correct code afterwards unlocks.
- Mid-entry long press after 1,2 → digits cleared, display_select=0; a following 1,2,3,4 unlocks.
- Short press in OPEN at cycle 100 → unlocked falls on the next edge. Reset asserted during LOCKOUT → all outputs 0 immediately.
- With LOCK_CODE_CHANGE_EN: unlock, long press, enter 9,8,7,6 → code 1234 now fails and 9876 unlocks.
